board_arbiter: RTL and testbench

BOARD_ARBITER -- requirements
Module: board_arbiter

---
 rtl/minesweeper_pkg.sv | 44 ++++
 rtl/board_arb_pick.sv | 56 +++++
 rtl/board_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_board_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
// minesweeper_pkg: shared constants for the minesweeper board datapath.
// Holds the cell codes, the requester indices, the "easy" board geometry,
// the arbiter state encoding and the round-robin helper.
package minesweeper_pkg;

   // Easy-level board geometry and the RAM address width it needs
   localparam int EZ_W      = 9;
   localparam int EZ_H      = 9;
   localparam int EZ_ADDR_W = 7;

   // Requester bookkeeping
   localparam int N_REQ      = 3;
   localparam int REQ_GEN    = 0;
   localparam int REQ_USER   = 1;
   localparam int REQ_RENDER = 2;

   // Field widths on the requester side
   localparam int COORD_W = 7;
   localparam int CELL_W  = 4;

   // Cell codes: 0..8 are neighbour mine counts
   localparam logic [3:0] CELL_MINE = 4'd9;
   localparam logic [3:0] CELL_FLAG = 4'd10;
   localparam logic [3:0] CELL_OOB  = 4'd15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2
   } arb_state_t;

   // Search start for the next round: the requester after the winner
   function automatic logic [1:0] rr_next(input logic [2:0] win);
      logic [1:0] nxt;
      case (win)
         3'b001:  nxt = 2'd1;
         3'b010:  nxt = 2'd2;
         3'b100:  nxt = 2'd0;
         default: nxt = 2'd0;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/board_arb_pick.sv
// board_arb_pick: combinational winner selection for board_arbiter.
// A live lock owner wins outright; otherwise the first requester found
// when searching upward from ptr (wrapping 2->0) wins. With ptr tied to
// zero this is plain fixed priority GEN > USER > RENDER.
module board_arb_pick
   import minesweeper_pkg::*;
(
   input  logic [2:0] req,
   input  logic [2:0] lock_own,
   input  logic [1:0] ptr,
   output logic [2:0] win
);

   logic [2:0] rot;
   logic [2:0] sel;
   logic [2:0] unrot;

   // Rotate requests so the search start sits at bit 0, pick, rotate back
   always_comb begin
      rot   = req;
      sel   = 3'b000;
      unrot = 3'b000;
      case (ptr)
         2'd0:    rot = req;
         2'd1:    rot = {req[0], req[2:1]};
         2'd2:    rot = {req[1:0], req[2]};
         default: rot = req;
      endcase
      if (rot[0]) begin
         sel = 3'b001;
      end else if (rot[1]) begin
         sel = 3'b010;
      end else if (rot[2]) begin
         sel = 3'b100;
      end else begin
         sel = 3'b000;
      end
      case (ptr)
         2'd0:    unrot = sel;
         2'd1:    unrot = {sel[1:0], sel[2]};
         2'd2:    unrot = {sel[0], sel[2:1]};
         default: unrot = sel;
      endcase
   end

   // Lock owner still requesting overrides the normal search
   always_comb begin
      win = 3'b000;
      if ((lock_own & req) != 3'b000) begin
         win = lock_own & req;
      end else begin
         win = unrot;
      end
   end

endmodule

// File: rtl/board_arbiter.sv
// board_arbiter: three-way arbiter in front of the single-port board RAM.
// Requesters GEN, USER and RENDER share one RAM port; each access is
// IDLE -> ACCESS (-> CAPTURE for reads) -> IDLE with registered outputs.
// Optional build macro: BOARD_ARB_RR_EN selects round-robin arbitration
// instead of fixed priority GEN > USER > RENDER.
module board_arbiter
   import minesweeper_pkg::*;
#(
   parameter int BD_W   = EZ_W,
   parameter int BD_H   = EZ_H,
   parameter int ADDR_W = EZ_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        req,
   input  logic [2:0]        we,
   input  logic [2:0]        lock,
   input  logic [20:0]       x_flat,
   input  logic [20:0]       y_flat,
   input  logic [11:0]       wdata_flat,
   output logic [2:0]        gnt,
   output logic [2:0]        rvalid,
   output logic [2:0]        done,
   output logic [3:0]        rdata,
   output logic              oob,
   output logic [ADDR_W-1:0] bd_addr,
   output logic [3:0]        bd_in,
   output logic              bd_wren,
   input  logic [3:0]        bd_out
);

   arb_state_t        state, nxt_state;
   logic [2:0]        win, nxt_win;
   logic              cur_we, nxt_cur_we;
   logic              cur_oob, nxt_cur_oob;
   logic [2:0]        lock_own, nxt_lock_own;
   logic [2:0]        pick;
   logic [1:0]        ptr;

   logic [COORD_W-1:0] sel_x, sel_y;
   logic [CELL_W-1:0]  sel_wd;
   logic               sel_we, sel_lock, sel_oob;
   logic [ADDR_W-1:0]  sel_addr;

   logic [2:0]         nxt_gnt, nxt_rvalid, nxt_done;
   logic [3:0]         nxt_rdata, nxt_bd_in;
   logic               nxt_oob, nxt_bd_wren;
   logic [ADDR_W-1:0]  nxt_bd_addr;

`ifdef BOARD_ARB_RR_EN
   // Round-robin pointer: next search starts just after the latest winner
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= 2'd0;
      end else if ((state == IDLE) && (req != 3'b000)) begin
         ptr <= rr_next(pick);
      end else begin
         ptr <= ptr;
      end
   end
`else
   assign ptr = 2'd0;
`endif

   board_arb_pick u_pick (
      .req      (req),
      .lock_own (lock_own),
      .ptr      (ptr),
      .win      (pick)
   );

   // Route the picked requester's fields and derive its RAM address
   always_comb begin
      sel_x    = '0;
      sel_y    = '0;
      sel_wd   = '0;
      sel_we   = 1'b0;
      sel_lock = 1'b0;
      case (pick)
         3'b001: begin
            sel_x    = x_flat[COORD_W*REQ_GEN +: COORD_W];
            sel_y    = y_flat[COORD_W*REQ_GEN +: COORD_W];
            sel_wd   = wdata_flat[CELL_W*REQ_GEN +: CELL_W];
            sel_we   = we[REQ_GEN];
            sel_lock = lock[REQ_GEN];
         end
         3'b010: begin
            sel_x    = x_flat[COORD_W*REQ_USER +: COORD_W];
            sel_y    = y_flat[COORD_W*REQ_USER +: COORD_W];
            sel_wd   = wdata_flat[CELL_W*REQ_USER +: CELL_W];
            sel_we   = we[REQ_USER];
            sel_lock = lock[REQ_USER];
         end
         3'b100: begin
            sel_x    = x_flat[COORD_W*REQ_RENDER +: COORD_W];
            sel_y    = y_flat[COORD_W*REQ_RENDER +: COORD_W];
            sel_wd   = wdata_flat[CELL_W*REQ_RENDER +: CELL_W];
            sel_we   = we[REQ_RENDER];
            sel_lock = lock[REQ_RENDER];
         end
         default: begin
            sel_x    = '0;
            sel_y    = '0;
            sel_wd   = '0;
            sel_we   = 1'b0;
            sel_lock = 1'b0;
         end
      endcase
      sel_oob  = (32'(sel_x) >= 32'(BD_W)) || (32'(sel_y) >= 32'(BD_H));
      // Modular arithmetic: truncating operands gives the truncated sum
      sel_addr = ADDR_W'(sel_y) * ADDR_W'(BD_W) + ADDR_W'(sel_x);
   end

   // Next-state and next-output decode; every output is registered below
   always_comb begin
      nxt_state    = state;
      nxt_win      = win;
      nxt_cur_we   = cur_we;
      nxt_cur_oob  = cur_oob;
      nxt_lock_own = lock_own;
      nxt_gnt      = 3'b000;
      nxt_rvalid   = 3'b000;
      nxt_done     = 3'b000;
      nxt_oob      = 1'b0;
      nxt_rdata    = rdata;
      nxt_bd_addr  = bd_addr;
      nxt_bd_in    = bd_in;
      nxt_bd_wren  = 1'b0;
      case (state)
         IDLE: begin
            if (req != 3'b000) begin
               nxt_state    = ACCESS;
               nxt_win      = pick;
               nxt_cur_we   = sel_we;
               nxt_cur_oob  = sel_oob;
               nxt_lock_own = sel_lock ? pick : 3'b000;
               nxt_gnt      = pick;
               nxt_bd_addr  = sel_oob ? '0 : sel_addr;
               nxt_bd_in    = sel_wd;
               nxt_bd_wren  = sel_we && !sel_oob;
            end else begin
               nxt_state = IDLE;
            end
         end
         ACCESS: begin
            if (cur_we) begin
               nxt_state = IDLE;
               nxt_done  = win;
               nxt_oob   = cur_oob;
            end else begin
               nxt_state = CAPTURE;
            end
         end
         CAPTURE: begin
            nxt_state  = IDLE;
            nxt_rvalid = win;
            nxt_done   = win;
            nxt_oob    = cur_oob;
            nxt_rdata  = cur_oob ? CELL_OOB : bd_out;
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   // State, access context and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         win      <= 3'b000;
         cur_we   <= 1'b0;
         cur_oob  <= 1'b0;
         lock_own <= 3'b000;
         gnt      <= 3'b000;
         rvalid   <= 3'b000;
         done     <= 3'b000;
         oob      <= 1'b0;
         rdata    <= 4'd0;
         bd_addr  <= '0;
         bd_in    <= 4'd0;
         bd_wren  <= 1'b0;
      end else begin
         state    <= nxt_state;
         win      <= nxt_win;
         cur_we   <= nxt_cur_we;
         cur_oob  <= nxt_cur_oob;
         lock_own <= nxt_lock_own;
         gnt      <= nxt_gnt;
         rvalid   <= nxt_rvalid;
         done     <= nxt_done;
         oob      <= nxt_oob;
         rdata    <= nxt_rdata;
         bd_addr  <= nxt_bd_addr;
         bd_in    <= nxt_bd_in;
         bd_wren  <= nxt_bd_wren;
      end
   end

endmodule

// File: tb/tb_board_arbiter.sv
// tb_board_arbiter: directed self-checking bench for board_arbiter with a
// small behavioural board RAM (address/data latched on clk, data out the
// cycle after). Inputs change and outputs are checked on the falling edge.
module tb_board_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req, we, lock;
   logic [20:0] x_flat, y_flat;
   logic [11:0] wdata_flat;
   logic [2:0]  gnt, rvalid, done;
   logic [3:0]  rdata;
   logic        oob;
   logic [6:0]  bd_addr;
   logic [3:0]  bd_in;
   logic        bd_wren;
   logic [3:0]  bd_out;

   logic [3:0]  mem [0:127];
   logic [2:0]  ord [3];
   logic [6:0]  ord_addr [3];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   board_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
      .x_flat(x_flat), .y_flat(y_flat), .wdata_flat(wdata_flat),
      .gnt(gnt), .rvalid(rvalid), .done(done), .rdata(rdata), .oob(oob),
      .bd_addr(bd_addr), .bd_in(bd_in), .bd_wren(bd_wren), .bd_out(bd_out)
   );

   // Board RAM model
   always @(posedge clk) begin
      if (bd_wren) mem[bd_addr] <= bd_in;
      bd_out <= mem[bd_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int r, input logic w, input logic l,
                          input logic [6:0] xx, input logic [6:0] yy, input logic [3:0] wd);
      we[r]                = w;
      lock[r]              = l;
      x_flat[7*r +: 7]     = xx;
      y_flat[7*r +: 7]     = yy;
      wdata_flat[4*r +: 4] = wd;
      req[r]               = 1'b1;
   endtask

   // One unopposed access from requester r, checked cycle by cycle
   task automatic single(input string tag, input int r, input logic w,
                         input logic [6:0] xx, input logic [6:0] yy, input logic [3:0] wd,
                         input logic [6:0] ea, input logic [3:0] erd, input logic eoob);
      logic [2:0] oh;
      oh = 3'b001 << r;
      set_req(r, w, 1'b0, xx, yy, wd);
      @(negedge clk);
      check({tag, ".gnt"}, gnt, oh);
      check({tag, ".addr"}, bd_addr, ea);
      check({tag, ".wren"}, bd_wren, w && !eoob);
      req[r] = 1'b0;
      @(negedge clk);
      if (w) begin
         check({tag, ".done"}, done, oh);
         check({tag, ".oob"}, oob, eoob);
         check({tag, ".wren_off"}, bd_wren, 1'b0);
         check({tag, ".gnt_off"}, gnt, 3'b000);
      end else begin
         check({tag, ".early_rvalid"}, rvalid, 3'b000);
         check({tag, ".early_done"}, done, 3'b000);
         @(negedge clk);
         check({tag, ".rvalid"}, rvalid, oh);
         check({tag, ".done"}, done, oh);
         check({tag, ".rdata"}, rdata, erd);
         check({tag, ".oob"}, oob, eoob);
      end
   endtask

   initial begin
      rst = 1'b0; req = 3'b000; we = 3'b000; lock = 3'b000;
      x_flat = '0; y_flat = '0; wdata_flat = '0;
`ifdef BOARD_ARB_RR_EN
      ord[0] = 3'b100; ord[1] = 3'b001; ord[2] = 3'b010;
      ord_addr[0] = 7'd2; ord_addr[1] = 7'd0; ord_addr[2] = 7'd1;
`else
      ord[0] = 3'b001; ord[1] = 3'b010; ord[2] = 3'b100;
      ord_addr[0] = 7'd0; ord_addr[1] = 7'd1; ord_addr[2] = 7'd2;
`endif

      // Reset state
      repeat (3) @(negedge clk);
      check("rst.gnt", gnt, 3'b000);
      check("rst.rvalid", rvalid, 3'b000);
      check("rst.done", done, 3'b000);
      check("rst.rdata", rdata, 4'd0);
      check("rst.oob", oob, 1'b0);
      check("rst.addr", bd_addr, 7'd0);
      check("rst.in", bd_in, 4'd0);
      check("rst.wren", bd_wren, 1'b0);
      rst = 1'b1;
      @(negedge clk);

      // USER write (3,2)=9 -> cell 21
      single("uwr", 1, 1'b1, 7'd3, 7'd2, 4'd9, 7'd21, 4'd0, 1'b0);
      check("uwr.mem21", mem[21], 4'd9);

      // Three simultaneous writes; last winner was USER
      set_req(0, 1'b1, 1'b0, 7'd0, 7'd0, 4'd1);
      set_req(1, 1'b1, 1'b0, 7'd1, 7'd0, 4'd2);
      set_req(2, 1'b1, 1'b0, 7'd2, 7'd0, 4'd3);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("prio.gnt", gnt, ord[k]);
         check("prio.addr", bd_addr, ord_addr[k]);
         req = req & ~ord[k];
         @(negedge clk);
         check("prio.done", done, ord[k]);
      end
      check("prio.mem0", mem[0], 4'd1);
      check("prio.mem1", mem[1], 4'd2);
      check("prio.mem2", mem[2], 4'd3);

      // Cell 21 = 4, then RENDER read returns it at cycle 3
      single("uwr4", 1, 1'b1, 7'd3, 7'd2, 4'd4, 7'd21, 4'd0, 1'b0);
      single("rrd", 2, 1'b0, 7'd3, 7'd2, 4'd0, 7'd21, 4'd4, 1'b0);

      // Out-of-range read and write
      single("oobrd", 0, 1'b0, 7'd9, 7'd0, 4'd0, 7'd0, 4'hF, 1'b1);
      single("oobwr", 0, 1'b1, 7'd0, 7'd9, 4'd5, 7'd0, 4'd0, 1'b1);
      check("oobwr.mem0", mem[0], 4'd1);

      // Locked read-modify-write of cell 40 while USER waits for cell 50
      single("uwr40", 1, 1'b1, 7'd4, 7'd4, 4'd6, 7'd40, 4'd0, 1'b0);
      set_req(1, 1'b1, 1'b0, 7'd5, 7'd5, 4'd2);
      set_req(0, 1'b0, 1'b1, 7'd4, 7'd4, 4'd0);
      @(negedge clk);
      check("lock.gnt1", gnt, 3'b001);
      check("lock.addr1", bd_addr, 7'd40);
      @(negedge clk);
      check("lock.wait", done, 3'b000);
      @(negedge clk);
      check("lock.rvalid", rvalid, 3'b001);
      check("lock.rdata", rdata, 4'd6);
      we[0] = 1'b1; lock[0] = 1'b0; wdata_flat[3:0] = 4'd7;
      @(negedge clk);
      check("lock.gnt2", gnt, 3'b001);
      check("lock.wren2", bd_wren, 1'b1);
      check("lock.in2", bd_in, 4'd7);
      req[0] = 1'b0;
      @(negedge clk);
      check("lock.done2", done, 3'b001);
      check("lock.mem40", mem[40], 4'd7);
      @(negedge clk);
      check("lock.gnt3", gnt, 3'b010);
      check("lock.addr3", bd_addr, 7'd50);
      req[1] = 1'b0;
      @(negedge clk);
      check("lock.done3", done, 3'b010);
      check("lock.mem50", mem[50], 4'd2);

      // Reset during a write ACCESS abandons it
      single("uwr10", 1, 1'b1, 7'd1, 7'd1, 4'd3, 7'd10, 4'd0, 1'b0);
      set_req(0, 1'b1, 1'b0, 7'd1, 7'd1, 4'd8);
      @(negedge clk);
      check("rstmid.gnt", gnt, 3'b001);
      check("rstmid.wren", bd_wren, 1'b1);
      rst = 1'b0;
      #1;
      check("rstmid.wren0", bd_wren, 1'b0);
      check("rstmid.gnt0", gnt, 3'b000);
      req = 3'b000;
      @(negedge clk);
      check("rstmid.done_in_rst", done, 3'b000);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid.done_after", done, 3'b000);
      check("rstmid.mem10", mem[10], 4'd3);
      single("post", 1, 1'b0, 7'd3, 7'd2, 4'd0, 7'd21, 4'd4, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
